// File: rtl/round_state_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : round_state_buffer_if
// Description : Writer/reader bundle between the AES round datapath and the
//               round-state store.
// Revision    : 1.0 - initial release
// ============================================================================
interface round_state_buffer_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] wr_ptr;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] last_out;
  logic              err;

  modport master (
    output start, wr_en, data_in, rd_en, rd_addr,
    input  rd_data, rd_valid, wr_ptr, busy, done, last_out, err
  );

  modport slave (
    input  start, wr_en, data_in, rd_en, rd_addr,
    output rd_data, rd_valid, wr_ptr, busy, done, last_out, err
  );
endinterface
`default_nettype wire

// File: rtl/round_state_buffer.sv
`default_nettype none
// ============================================================================
// Module      : round_state_buffer
// Description : NR+1 entry AES round-state store with valid tracking,
//               write-first registered reads and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module round_state_buffer #(
  parameter int DATA_W = 128,
  parameter int NR     = 10,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  round_state_buffer_if.slave bus
);

  localparam int DEPTH = NR + 1;
  localparam int SPAN  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(NR);
  localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_last_out;
  logic              r_err;

  logic              w_wr_ok;
  logic              w_wr_err;
  logic              w_wr_last;
  logic              w_busy;
  logic              w_done;
  logic              w_rd_hit;
  logic [DATA_W-1:0] w_rd_word;
  logic [SPAN-1:0]   w_valid_span;

  // start always wins over a same-cycle wr_en, and the dropped write is silent
  assign w_wr_ok      = bus.wr_en & ~bus.start & (r_state == S_FILL);
  assign w_wr_err     = bus.wr_en & ~bus.start & (r_state != S_FILL);
  assign w_wr_last    = w_wr_ok & (r_wr_ptr == c_last);
  assign w_valid_span = SPAN'(r_valid);

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = r_state;
      S_FILL: begin
        w_busy = 1'b1;
        if (w_wr_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_done = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.start) begin
      w_state_nxt = S_FILL;
    end
  end

  // Write-first bypass; a start invalidates every entry except the new entry 0
  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_word = '0;
    if (bus.start) begin
      if (bus.rd_addr == '0) begin
        w_rd_hit  = 1'b1;
        w_rd_word = bus.data_in;
      end
    end else if (w_wr_ok && (bus.rd_addr == r_wr_ptr)) begin
      w_rd_hit  = 1'b1;
      w_rd_word = bus.data_in;
    end else if ((bus.rd_addr <= c_last) && w_valid_span[bus.rd_addr]) begin
      w_rd_hit  = 1'b1;
      w_rd_word = r_mem[bus.rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_wr_ptr   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_last_out <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_wr_err | (bus.rd_en & ~w_rd_hit);
      if (bus.start) begin
        r_valid    <= DEPTH'(1);
        r_wr_ptr   <= c_one;
        r_last_out <= '0;
      end else if (w_wr_ok) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + c_one;
        if (w_wr_last) begin
          r_last_out <= bus.data_in;
        end
      end
      if (bus.rd_en) begin
        r_rd_valid <= w_rd_hit;
        r_rd_data  <= w_rd_hit ? w_rd_word : '0;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  // Storage is not reset; the valid map alone decides what is readable
  always_ff @(posedge clk) begin
    if (bus.start) begin
      r_mem[0] <= bus.data_in;
    end else if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.wr_ptr   = r_wr_ptr;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.last_out = r_last_out;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_round_state_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_state_buffer
// Description : Directed scoreboard bench for round_state_buffer at NR=10/128b
//               and NR=14/32b.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_state_buffer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  typedef struct {
    logic         re;
    logic         ev;
    logic [127:0] ed;
    logic         ee;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];

  round_state_buffer_if #(.DATA_W(128), .ADDR_W(4)) a_if ();
  round_state_buffer_if #(.DATA_W(32),  .ADDR_W(4)) b_if ();

  round_state_buffer #(.DATA_W(128), .NR(10), .ADDR_W(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  round_state_buffer #(.DATA_W(32), .NR(14), .ADDR_W(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_step(input logic st, input logic we, input logic [127:0] din,
                        input logic re, input logic [3:0] ra,
                        input logic ev, input logic [127:0] ed, input logic ee);
    exp_t e;
    a_if.start   = st;
    a_if.wr_en   = we;
    a_if.data_in = din;
    a_if.rd_en   = re;
    a_if.rd_addr = ra;
    e.re = re; e.ev = ev; e.ed = ed; e.ee = ee;
    a_q.push_back(e);
    @(posedge clk);
    #1;
    e = a_q.pop_front();
    check("a_err", a_if.err, e.ee);
    check("a_rd_valid", a_if.rd_valid, e.ev);
    if (e.re) check("a_rd_data", a_if.rd_data, e.ed);
  endtask

  task automatic b_step(input logic st, input logic we, input logic [31:0] din,
                        input logic re, input logic [3:0] ra,
                        input logic ev, input logic [31:0] ed, input logic ee);
    exp_t e;
    b_if.start   = st;
    b_if.wr_en   = we;
    b_if.data_in = din;
    b_if.rd_en   = re;
    b_if.rd_addr = ra;
    e.re = re; e.ev = ev; e.ed = 128'(ed); e.ee = ee;
    b_q.push_back(e);
    @(posedge clk);
    #1;
    e = b_q.pop_front();
    check("b_err", b_if.err, e.ee);
    check("b_rd_valid", b_if.rd_valid, e.ev);
    if (e.re) check("b_rd_data", b_if.rd_data, e.ed);
  endtask

  localparam logic [127:0] K0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] K1 = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] K2 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] K3 = 128'hCAFEBABE0000111122223333DEADBEEF;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    a_if.start = 1'b0; a_if.wr_en = 1'b0; a_if.data_in = '0; a_if.rd_en = 1'b0; a_if.rd_addr = '0;
    b_if.start = 1'b0; b_if.wr_en = 1'b0; b_if.data_in = '0; b_if.rd_en = 1'b0; b_if.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_rd_data", a_if.rd_data, 128'd0);
    check("rst_rd_valid", a_if.rd_valid, 1'b0);
    check("rst_wr_ptr", a_if.wr_ptr, 4'd0);
    check("rst_busy", a_if.busy, 1'b0);
    check("rst_done", a_if.done, 1'b0);
    check("rst_last_out", a_if.last_out, 128'd0);
    check("rst_err", a_if.err, 1'b0);

    a_step(0, 0, '0, 1, 4'd0, 0, '0, 1);
    a_step(0, 0, '0, 0, 4'd0, 0, '0, 0);

    a_step(1, 0, K0, 0, 4'd0, 0, '0, 0);
    check("start_busy", a_if.busy, 1'b1);
    check("start_wr_ptr", a_if.wr_ptr, 4'd1);
    check("start_done", a_if.done, 1'b0);
    for (int r = 1; r <= 10; r++) begin
      a_step(0, 1, rep(8'(r)), 0, 4'd0, 0, '0, 0);
      if (r == 9) check("fill9_done", a_if.done, 1'b0);
    end
    check("fill_done", a_if.done, 1'b1);
    check("fill_busy", a_if.busy, 1'b0);
    check("fill_last_out", a_if.last_out, rep(8'h0A));
    check("fill_wr_ptr", a_if.wr_ptr, 4'd11);

    for (int i = 0; i <= 10; i++) begin
      a_step(0, 0, '0, 1, 4'(i), 1, (i == 0) ? K0 : rep(8'(i)), 0);
    end

    a_step(0, 1, rep(8'h99), 0, 4'd0, 0, '0, 1);
    check("xs_last_out", a_if.last_out, rep(8'h0A));
    check("xs_wr_ptr", a_if.wr_ptr, 4'd11);
    a_step(0, 0, '0, 1, 4'd10, 1, rep(8'h0A), 0);
    a_step(0, 0, '0, 1, 4'd11, 0, '0, 1);
    a_step(0, 0, '0, 1, 4'd15, 0, '0, 1);
    a_step(0, 0, '0, 0, 4'd0, 0, '0, 0);

    a_step(1, 0, K1, 0, 4'd0, 0, '0, 0);
    a_step(0, 1, rep(8'h21), 0, 4'd0, 0, '0, 0);
    a_step(0, 1, rep(8'h22), 0, 4'd0, 0, '0, 0);
    a_step(0, 1, rep(8'h33), 1, 4'd3, 1, rep(8'h33), 0);
    a_step(0, 1, rep(8'h44), 0, 4'd0, 0, '0, 0);
    check("mid_wr_ptr", a_if.wr_ptr, 4'd5);
    a_step(1, 0, K2, 1, 4'd4, 0, '0, 1);
    check("restart_wr_ptr", a_if.wr_ptr, 4'd1);
    a_step(1, 0, K3, 1, 4'd0, 1, K3, 0);
    a_step(0, 1, rep(8'h51), 0, 4'd0, 0, '0, 0);
    a_step(0, 1, rep(8'h52), 1, 4'd1, 1, rep(8'h51), 0);

    a_if.wr_en = 1'b0; a_if.rd_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_rd_valid", a_if.rd_valid, 1'b0);
    check("arst_rd_data", a_if.rd_data, 128'd0);
    check("arst_busy", a_if.busy, 1'b0);
    check("arst_wr_ptr", a_if.wr_ptr, 4'd0);
    check("arst_last_out", a_if.last_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    a_step(0, 0, '0, 1, 4'd1, 0, '0, 1);
    a_step(0, 0, '0, 0, 4'd0, 0, '0, 0);

    b_step(1, 0, 32'hDEADBEEF, 0, 4'd0, 0, '0, 0);
    for (int r = 1; r <= 14; r++) begin
      b_step(0, 1, 32'h1000_0000 + 32'(r), 0, 4'd0, 0, '0, 0);
      if (r == 13) check("b_fill13_done", b_if.done, 1'b0);
    end
    check("b_done", b_if.done, 1'b1);
    check("b_last_out", b_if.last_out, 128'h1000_000E);
    check("b_wr_ptr", b_if.wr_ptr, 4'd15);
    b_step(0, 0, '0, 1, 4'd14, 1, 32'h1000_000E, 0);
    b_step(0, 0, '0, 1, 4'd0, 1, 32'hDEADBEEF, 0);
    b_step(0, 0, '0, 1, 4'd15, 0, '0, 1);
    b_step(0, 0, '0, 0, 4'd0, 0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
